// File: rtl/shift_reg_ctrl.sv
// shift_reg_ctrl: burst-controlled multi-mode shift register; define SHREG_PARITY_EN to drive parity with ^q
module shift_reg_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] count,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done,
  output logic             parity
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic ser_q, ser_d;
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    rem_d = rem_q;
    q_d = q_q;
    ser_d = ser_q;
    case (state_q)
      IDLE: if (start && ena) begin
        op_d = mode;
        rem_d = count;
        state_d = (count == '0 || mode > 3'd5) ? FIN : RUN;
      end
      RUN: if (ena) begin
        case (op_q)
          3'd0: q_d = load_data;
          3'd1: begin q_d = {q_q[WIDTH-2:0], ser_in}; ser_d = q_q[WIDTH-1]; end
          3'd2: begin q_d = {ser_in, q_q[WIDTH-1:1]}; ser_d = q_q[0]; end
          3'd3: begin q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]}; ser_d = q_q[WIDTH-1]; end
          3'd4: begin q_d = {q_q[0], q_q[WIDTH-1:1]}; ser_d = q_q[0]; end
          default: q_d = '0;
        endcase
        rem_d = rem_q - CNT_W'(1);
        state_d = (rem_q == CNT_W'(1)) ? FIN : RUN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= '0;
      rem_q <= '0;
      q_q <= '0;
      ser_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      rem_q <= rem_d;
      q_q <= q_d;
      ser_q <= ser_d;
    end
  end
  assign q = q_q;
  assign ser_out = ser_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == FIN);
`ifdef SHREG_PARITY_EN
  assign parity = ^q_q;
`else
  assign parity = 1'b0;
`endif
endmodule

// File: tb/tb_shift_reg_ctrl.sv
// tb_shift_reg_ctrl: directed bursts checked against a behavioural model every cycle plus literal expectations
module tb_shift_reg_ctrl;
  logic clk = 1'b0, rst = 1'b1, ena = 1'b1, start = 1'b0, ser_in = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [3:0] count = 4'd0;
  logic [7:0] load_data = 8'h00;
  logic [7:0] q;
  logic ser_out, busy, done, parity;
  int errors = 0, checks = 0;
`ifdef SHREG_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  shift_reg_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .mode(mode), .count(count),
    .ser_in(ser_in), .load_data(load_data), .q(q), .ser_out(ser_out),
    .busy(busy), .done(done), .parity(parity)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  logic [7:0] m_q = 8'h00;
  logic m_ser = 1'b0;
  bit m_busy = 0, m_done = 0;
  int m_rem = 0;
  int m_op = 0;
  always @(posedge clk) begin
    if (rst) begin
      m_q = 8'h00; m_ser = 1'b0; m_busy = 0; m_done = 0; m_rem = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      if (ena) begin
        case (m_op)
          0: m_q = load_data;
          1: begin m_ser = m_q[7]; m_q = 8'((m_q << 1) | 8'(ser_in)); end
          2: begin m_ser = m_q[0]; m_q = 8'((m_q >> 1) | (8'(ser_in) << 7)); end
          3: begin m_ser = m_q[7]; m_q = 8'((m_q << 1) | (m_q >> 7)); end
          4: begin m_ser = m_q[0]; m_q = 8'((m_q >> 1) | (m_q << 7)); end
          default: m_q = 8'h00;
        endcase
        m_rem--;
        if (m_rem == 0) begin m_busy = 0; m_done = 1; end
      end
    end else if (start && ena) begin
      m_op = int'(mode);
      m_rem = int'(count);
      if (count == 0 || mode > 3'd5) m_done = 1; else m_busy = 1;
    end
  end
  always @(posedge clk) begin
    #2;
    chk("q", 32'(q), 32'(m_q));
    chk("ser_out", 32'(ser_out), 32'(m_ser));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("parity", 32'(parity), 32'(PEN ? ^m_q : 1'b0));
  end
  int dc, bc;
  task automatic run(input logic [2:0] md, input logic [3:0] cnt, input logic [7:0] ld,
                     input logic [31:0] sbits, input logic [31:0] emask, input logic [31:0] smask,
                     output int done_cycle, output int busy_cycles);
    done_cycle = -1;
    busy_cycles = 0;
    @(negedge clk);
    start = 1'b1; mode = md; count = cnt; load_data = ld; ena = 1'b1; ser_in = sbits[0];
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #2;
      if (busy) busy_cycles++;
      if (done) begin done_cycle = c + 1; break; end
      @(negedge clk);
      start = smask[c+1]; ena = emask[c+1]; ser_in = sbits[c+1];
    end
    if (done_cycle < 0) chk("done_timeout", 32'(0), 32'(1));
    @(negedge clk);
    start = 1'b0; ena = 1'b1;
    @(negedge clk);
  endtask
  localparam logic [31:0] ALL = 32'hFFFF_FFFF;
  initial begin
    int extra;
    start = 1'b1; mode = 3'd0; load_data = 8'hFF; count = 4'd1;
    repeat (2) begin
      @(posedge clk); #2;
      chk("rst_q", 32'(q), 32'h00);
      chk("rst_busy", 32'(busy), 32'(0));
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #2;
    chk("post_rst_q", 32'(q), 32'h00);
    chk("post_rst_done", 32'(done), 32'(0));
    run(3'd0, 4'd1, 8'hA5, 0, ALL, 0, dc, bc);
    chk("load_done_cycle", 32'(dc), 32'(2));
    chk("load_busy_cycles", 32'(bc), 32'(1));
    chk("load_q", 32'(q), 32'hA5);
    run(3'd1, 4'd3, 8'h00, 32'b1010, ALL, 0, dc, bc);
    chk("shl_done_cycle", 32'(dc), 32'(4));
    chk("shl_q", 32'(q), 32'h2D);
    chk("shl_ser", 32'(ser_out), 32'(1));
    run(3'd0, 4'd1, 8'h81, 0, ALL, 0, dc, bc);
    run(3'd4, 4'd9, 8'h00, 0, ALL, 0, dc, bc);
    chk("ror_done_cycle", 32'(dc), 32'(10));
    chk("ror_q", 32'(q), 32'hC0);
    chk("ror_ser", 32'(ser_out), 32'(1));
    run(3'd3, 4'd8, 8'h00, 0, ALL, 0, dc, bc);
    chk("rol_q", 32'(q), 32'hC0);
    chk("rol_done_cycle", 32'(dc), 32'(9));
    run(3'd0, 4'd1, 8'hF0, 0, ALL, 0, dc, bc);
    run(3'd2, 4'd4, 8'h00, 0, ~32'h38, 0, dc, bc);
    chk("pause_done_cycle", 32'(dc), 32'(8));
    chk("pause_busy_cycles", 32'(bc), 32'(7));
    chk("pause_q", 32'(q), 32'h0F);
    run(3'd0, 4'd0, 8'hFF, 0, ALL, 0, dc, bc);
    chk("cnt0_done_cycle", 32'(dc), 32'(1));
    chk("cnt0_busy_cycles", 32'(bc), 32'(0));
    chk("cnt0_q", 32'(q), 32'h0F);
    run(3'd6, 4'd3, 8'hFF, 0, ALL, 0, dc, bc);
    chk("rsv_done_cycle", 32'(dc), 32'(1));
    chk("rsv_busy_cycles", 32'(bc), 32'(0));
    chk("rsv_q", 32'(q), 32'h0F);
    run(3'd1, 4'd5, 8'h00, ALL, ALL, 32'b1100, dc, bc);
    chk("restart_done_cycle", 32'(dc), 32'(6));
    chk("restart_q", 32'(q), 32'hFF);
    extra = 0;
    repeat (4) begin
      @(posedge clk); #2;
      if (done || busy) extra++;
    end
    chk("restart_not_queued", 32'(extra), 32'(0));
    run(3'd0, 4'd1, 8'h07, 0, ALL, 0, dc, bc);
    chk("parity_07", 32'(parity), 32'(PEN));
    run(3'd5, 4'd2, 8'h00, 0, ALL, 0, dc, bc);
    chk("clear_q", 32'(q), 32'h00);
    chk("parity_clear", 32'(parity), 32'(0));
    run(3'd0, 4'd1, 8'h3C, 0, ALL, 0, dc, bc);
    @(negedge clk);
    start = 1'b1; mode = 3'd3; count = 4'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #2;
    chk("midrst_q", 32'(q), 32'h00);
    chk("midrst_busy", 32'(busy), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("midrst_idle_done", 32'(done), 32'(0));
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
